hazard_stall_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_stall_unit_md_busy_timer.sv | 35 +++
 rtl/hazard_stall_unit.sv | 72 +++++++
 tb/tb_hazard_stall_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard stall unit
package hazard_pkg;
  typedef enum logic {IDLE, MD_RUN} md_state_t;
  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return dst != REG_ZERO && dst == src;
  endfunction
endpackage

// File: rtl/hazard_stall_unit_md_busy_timer.sv
// md_busy_timer: tracks the in-flight multiply/divide and pulses done when HI/LO is written
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] latency,
  output logic             busy,
  output logic             done
);
  md_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic run, last;
  assign run  = state == MD_RUN;
  assign last = run && cnt == '0;
  assign busy = run;
  always_comb begin
    state_nx = last ? IDLE : (load && !run) ? MD_RUN : state;
    cnt_nx   = run ? (last ? cnt : cnt - CNT_W'(1)) : load ? latency - CNT_W'(1) : cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= last;
    end
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage stall/flush control for load-use, branch-in-ID and mult/div hazards
// Define HAZARD_STATS_EN to enable the StallCycles/FlushCycles counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_rs,
  input  logic [4:0]  IFID_rt,
  input  logic        IFID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_MdStart,
  input  logic        ID_MdOp,
  input  logic        ID_ReadsHiLo,
  input  logic        IDEX_MemRd,
  input  logic        IDEX_RegWr,
  input  logic [4:0]  IDEX_rdes,
  input  logic        EXMEM_MemRd,
  input  logic [4:0]  EXMEM_rdes,
  input  logic        EX_Redirect,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic        MD_Busy,
  output logic        MD_Done,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCycles
);
  logic ex_rs, ex_rt, load_use, br_ex, br_mem, md_hazard, stall, busy, issue;
  assign ex_rs     = reg_hit(IDEX_rdes, IFID_rs);
  assign ex_rt     = IFID_UsesRt && reg_hit(IDEX_rdes, IFID_rt);
  assign load_use  = IDEX_MemRd && (ex_rs || ex_rt);
  assign br_ex     = ID_Branch && IDEX_RegWr && (ex_rs || ex_rt);
  assign br_mem    = ID_Branch && EXMEM_MemRd &&
                     (reg_hit(EXMEM_rdes, IFID_rs) || reg_hit(EXMEM_rdes, IFID_rt));
  assign md_hazard = busy && (ID_MdStart || ID_ReadsHiLo);
  assign stall     = load_use || br_ex || br_mem || md_hazard;
  // a redirect squashes the ID instruction, so it must not start the unit
  assign issue     = ID_MdStart && !stall && !EX_Redirect;
  md_busy_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (issue),
    .latency (ID_MdOp == MD_DIV ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT)),
    .busy    (busy),
    .done    (MD_Done)
  );
  assign PC_Write    = rst_n && (EX_Redirect || !stall);
  assign IFID_Write  = rst_n && (EX_Redirect || !stall);
  assign IDEX_Bubble = !rst_n || EX_Redirect || stall;
  assign IFID_Flush  = !rst_n || EX_Redirect;
  assign MD_Busy     = rst_n && busy;
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else begin
      StallCycles <= StallCycles + 32'(stall && !EX_Redirect);
      FlushCycles <= FlushCycles + 32'(EX_Redirect);
    end
  end
`else
  assign StallCycles = '0;
  assign FlushCycles = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed and random checks of hazard_stall_unit against a cycle model
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, IFID_UsesRt, ID_Branch, ID_MdStart, ID_MdOp, ID_ReadsHiLo;
  logic IDEX_MemRd, IDEX_RegWr, EXMEM_MemRd, EX_Redirect;
  logic [4:0] IFID_rs, IFID_rt, IDEX_rdes, EXMEM_rdes;
  logic PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Busy, MD_Done;
  logic [31:0] StallCycles, FlushCycles;
  int n_chk = 0, n_fail = 0;
  int md_left = 0;
  logic md_done = 1'b0;
  logic [31:0] st_cnt = 0, fl_cnt = 0;
  logic obs_pc, obs_done, obs_flush, obs_busy;

  hazard_stall_unit #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_UsesRt(IFID_UsesRt),
    .ID_Branch(ID_Branch), .ID_MdStart(ID_MdStart), .ID_MdOp(ID_MdOp), .ID_ReadsHiLo(ID_ReadsHiLo),
    .IDEX_MemRd(IDEX_MemRd), .IDEX_RegWr(IDEX_RegWr), .IDEX_rdes(IDEX_rdes),
    .EXMEM_MemRd(EXMEM_MemRd), .EXMEM_rdes(EXMEM_rdes), .EX_Redirect(EX_Redirect),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done), .StallCycles(StallCycles), .FlushCycles(FlushCycles)
  );

  task automatic chk1(input string tag, input logic o, input logic e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic logic same_reg(input logic [4:0] d, input logic [4:0] s);
    return d != 0 && d == s;
  endfunction

  function automatic logic model_stall();
    logic lu, bex, bmem, md;
    lu   = IDEX_MemRd && (same_reg(IDEX_rdes, IFID_rs) || (IFID_UsesRt && same_reg(IDEX_rdes, IFID_rt)));
    bex  = ID_Branch && IDEX_RegWr && (same_reg(IDEX_rdes, IFID_rs) || (IFID_UsesRt && same_reg(IDEX_rdes, IFID_rt)));
    bmem = ID_Branch && EXMEM_MemRd && (same_reg(EXMEM_rdes, IFID_rs) || same_reg(EXMEM_rdes, IFID_rt));
    md   = md_left > 0 && (ID_MdStart || ID_ReadsHiLo);
    return lu || bex || bmem || md;
  endfunction

  task automatic step();
    logic s, e_pc, e_bub, e_fl;
    logic [31:0] e_st, e_fc;
    @(negedge clk);
    s = model_stall();
    if (!rst_n) begin e_pc = 0; e_bub = 1; e_fl = 1; end
    else if (EX_Redirect) begin e_pc = 1; e_bub = 1; e_fl = 1; end
    else if (s) begin e_pc = 0; e_bub = 1; e_fl = 0; end
    else begin e_pc = 1; e_bub = 0; e_fl = 0; end
`ifdef HAZARD_STATS_EN
    e_st = st_cnt; e_fc = fl_cnt;
`else
    e_st = 0; e_fc = 0;
`endif
    chk1("PC_Write", PC_Write, e_pc);
    chk1("IFID_Write", IFID_Write, e_pc);
    chk1("IDEX_Bubble", IDEX_Bubble, e_bub);
    chk1("IFID_Flush", IFID_Flush, e_fl);
    chk1("MD_Busy", MD_Busy, rst_n && md_left > 0);
    chk1("MD_Done", MD_Done, md_done);
    chk32("StallCycles", StallCycles, e_st);
    chk32("FlushCycles", FlushCycles, e_fc);
    obs_pc = PC_Write; obs_done = MD_Done; obs_flush = IFID_Flush; obs_busy = MD_Busy;
    @(posedge clk);
    if (!rst_n) begin
      md_left = 0; md_done = 0; st_cnt = 0; fl_cnt = 0;
    end else begin
      md_done = md_left == 1;
      if (md_left > 0) md_left--;
      else if (ID_MdStart && !s && !EX_Redirect) md_left = ID_MdOp ? 32 : 4;
      if (EX_Redirect) fl_cnt++;
      else if (s) st_cnt++;
    end
    #1;
  endtask

  task automatic clr();
    rst_n = 1; IFID_rs = 0; IFID_rt = 0; IFID_UsesRt = 0; ID_Branch = 0; ID_MdStart = 0;
    ID_MdOp = 0; ID_ReadsHiLo = 0; IDEX_MemRd = 0; IDEX_RegWr = 0; IDEX_rdes = 0;
    EXMEM_MemRd = 0; EXMEM_rdes = 0; EX_Redirect = 0;
  endtask

  initial begin
    int stalls, dones;
    logic saw_done;
    clr(); rst_n = 0;
    @(posedge clk); #1;
    step(); step();
    chk1("rst_pc", obs_pc, 0);
    chk1("rst_flush", obs_flush, 1);
    clr(); step();
    // load-use on $5, then the load moves to MEM
    IDEX_MemRd = 1; IDEX_rdes = 5; IFID_rs = 5; step();
    chk1("lu_stall", obs_pc, 0);
    IDEX_MemRd = 0; IDEX_rdes = 0; EXMEM_MemRd = 1; EXMEM_rdes = 5; step();
    chk1("lu_release", obs_pc, 1);
    clr(); IDEX_MemRd = 1; IDEX_rdes = 0; IFID_rs = 0; step();
    chk1("lu_r0", obs_pc, 1);
    clr(); ID_Branch = 1; IDEX_RegWr = 1; IDEX_rdes = 7; IFID_rt = 7; IFID_rs = 3; IFID_UsesRt = 1; step();
    chk1("br_ex", obs_pc, 0);
    IDEX_RegWr = 0; IDEX_rdes = 0; EXMEM_MemRd = 1; EXMEM_rdes = 7; step();
    chk1("br_mem", obs_pc, 0);
    clr(); ID_Branch = 1; IFID_rt = 7; IFID_UsesRt = 1; step();
    chk1("br_clear", obs_pc, 1);
    // mult then mfhi
    clr(); ID_MdStart = 1; ID_MdOp = 0; step();
    clr(); ID_ReadsHiLo = 1; stalls = 0; saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_pc) begin saw_done = obs_done; break; end
      stalls++;
    end
    chk32("mfhi_stall_len", stalls, 4);
    chk1("mfhi_done", saw_done, 1);
    // redirect dominates stall; redirect cancels issue
    clr(); IDEX_MemRd = 1; IDEX_rdes = 9; IFID_rs = 9; EX_Redirect = 1; step();
    chk1("redir_pc", obs_pc, 1);
    chk1("redir_flush", obs_flush, 1);
    clr(); ID_MdStart = 1; ID_MdOp = 1; EX_Redirect = 1; step();
    clr(); step();
    chk1("div_redir_busy", obs_busy, 0);
    // reset in the middle of a div
    clr(); ID_MdStart = 1; ID_MdOp = 1; step();
    clr();
    for (int i = 0; i < 9; i++) step();
    rst_n = 0; step();
    rst_n = 1; dones = 0;
    for (int i = 0; i < 35; i++) begin step(); dones += int'(obs_done); end
    chk32("rst_div_no_done", dones, 0);
    chk1("rst_div_busy", obs_busy, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(63) != 0;
      IFID_rs = 5'($urandom_range(3)); IFID_rt = 5'($urandom_range(3));
      ID_Branch = $urandom_range(3) == 0;
      IFID_UsesRt = ID_Branch ? 1'b1 : 1'($urandom_range(1));
      ID_MdStart = $urandom_range(7) == 0; ID_MdOp = 1'($urandom_range(1));
      ID_ReadsHiLo = $urandom_range(5) == 0;
      IDEX_MemRd = $urandom_range(3) == 0; IDEX_RegWr = 1'($urandom_range(1));
      IDEX_rdes = 5'($urandom_range(3));
      EXMEM_MemRd = $urandom_range(3) == 0; EXMEM_rdes = 5'($urandom_range(3));
      EX_Redirect = $urandom_range(9) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
